fetch_stage: RTL and testbench

//   Instruction-fetch (IF) stage of the 8-bit pipelined processor; feeds the IF/ID register consumed by decode.

---
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 8-bit pipeline; owns the PC and loads it from the reset and interrupt vectors
// Ports: clk, rst (async, active-high); imem_addr/imem_rdata: combinational instruction port;
//   stall, flush, redirect_pc, halt, int_req: control from hazard unit / decode / external interrupt;
//   if_valid, if_instr, if_pc_next, if_int: IF/ID register; hlt_o: processor halted.
// int_req carries the external interrupt request (the bare name is a reserved word).
// Optional INT_SYNC_EN: int_req passes through a 2-flop synchronizer before edge detection.
module fetch_stage #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR   = 8'h01,
  parameter logic [7:0] NOP_OPCODE     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       stall,
  input  logic       flush,
  input  logic [7:0] redirect_pc,
  input  logic       halt,
  input  logic       int_req,
  output logic       if_valid,
  output logic [7:0] if_instr,
  output logic [7:0] if_pc_next,
  output logic       if_int,
  output logic       hlt_o
);
  typedef enum logic [1:0] {RST_VEC, RUN, INT_VEC, HALT} state_t;
  state_t state;
  logic [7:0] pc;
  logic int_pending, int_prev, int_s, int_rise;
`ifdef INT_SYNC_EN
  logic [1:0] int_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) int_sync <= '0;
    else int_sync <= {int_sync[0], int_req};
  assign int_s = int_sync[1];
`else
  assign int_s = int_req;
`endif
  assign int_rise = int_s & ~int_prev;
  assign imem_addr = state == RST_VEC ? RESET_VEC_ADDR : state == INT_VEC ? INT_VEC_ADDR : pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_VEC;
      pc          <= 8'h00;
      if_valid    <= 1'b0;
      if_instr    <= NOP_OPCODE;
      if_pc_next  <= 8'h00;
      if_int      <= 1'b0;
      hlt_o       <= 1'b0;
      int_pending <= 1'b0;
      int_prev    <= 1'b0;
    end else begin
      int_prev    <= int_s;
      // a new edge in the same cycle as the vector load re-arms the latch
      int_pending <= int_rise | (int_pending & ~(state == INT_VEC && !stall));
      case (state)
        RST_VEC: begin
          pc    <= imem_rdata;
          state <= RUN;
        end
        RUN:
          if (flush) begin
            pc       <= redirect_pc;
            if_instr <= NOP_OPCODE;
            if_valid <= 1'b0;
            if_int   <= 1'b0;
          end else if (halt) begin
            state    <= HALT;
            if_valid <= 1'b0;
            if_instr <= NOP_OPCODE;
            hlt_o    <= 1'b1;
          end else if (!stall) begin
            if (int_pending) begin
              // bubble carries the interrupted PC as the return address
              if_int     <= 1'b1;
              if_valid   <= 1'b0;
              if_instr   <= NOP_OPCODE;
              if_pc_next <= pc;
              state      <= INT_VEC;
            end else begin
              if_instr   <= imem_rdata;
              if_pc_next <= pc + 8'd1;
              if_valid   <= 1'b1;
              pc         <= pc + 8'd1;
            end
          end
        INT_VEC:
          if (!stall) begin
            pc     <= imem_rdata;
            if_int <= 1'b0;
            state  <= RUN;
          end
        HALT:
          if (int_pending) begin
            hlt_o      <= 1'b0;
            if_int     <= 1'b1;
            if_valid   <= 1'b0;
            if_instr   <= NOP_OPCODE;
            if_pc_next <= pc;
            state      <= INT_VEC;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic stall = 1'b0, flush = 1'b0, halt = 1'b0, int_req = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic [7:0] imem_addr, imem_rdata, if_instr, if_pc_next;
  logic if_valid, if_int, hlt_o;
  logic [7:0] mem [256];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];
  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .halt(halt), .int_req(int_req),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_next(if_pc_next), .if_int(if_int), .hlt_o(hlt_o)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {7'd0, if_valid}, 8'h00);
    chk({tag, "_instr"}, if_instr, 8'h00);
    chk({tag, "_pcn"}, if_pc_next, 8'h00);
    chk({tag, "_int"}, {7'd0, if_int}, 8'h00);
    chk({tag, "_hlt"}, {7'd0, hlt_o}, 8'h00);
    chk({tag, "_addr"}, imem_addr, 8'h00);
    chk({tag, "_pc"}, dut.pc, 8'h00);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h02; mem[8'h01] = 8'h6E; mem[8'h02] = 8'h21; mem[8'h03] = 8'h33;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'hB6; mem[8'hFF] = 8'h21; mem[8'h6E] = 8'h44;
    #2;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("vec_pc", dut.pc, 8'h02);
    chk("vec_valid", {7'd0, if_valid}, 8'h00);
    step();
    chk("f1_instr", if_instr, 8'h21);
    chk("f1_pcn", if_pc_next, 8'h03);
    chk("f1_addr", imem_addr, 8'h03);
    chk("f1_valid", {7'd0, if_valid}, 8'h01);
    // interrupt edge arrives while stalled at PC=03
    stall = 1'b1; int_req = 1'b1;
    step();
    chk("i_stall_addr", imem_addr, 8'h03);
    chk("i_pend", {7'd0, dut.int_pending}, 8'h01);
    chk("i_stall_instr", if_instr, 8'h21);
    stall = 1'b0; int_req = 1'b0;
    step();
    chk("i_bub_int", {7'd0, if_int}, 8'h01);
    chk("i_bub_pcn", if_pc_next, 8'h03);
    chk("i_bub_valid", {7'd0, if_valid}, 8'h00);
    chk("i_bub_addr", imem_addr, 8'h01);
    step();
    chk("i_vec_pc", imem_addr, 8'h6E);
    chk("i_vec_pend", {7'd0, dut.int_pending}, 8'h00);
    chk("i_vec_int", {7'd0, if_int}, 8'h00);
    flush = 1'b1; redirect_pc = 8'h10;
    step();
    flush = 1'b0;
    chk("fl10_addr", imem_addr, 8'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_addr", imem_addr, 8'h10);
      chk("st_instr", if_instr, 8'h00);
    end
    stall = 1'b0;
    step();
    chk("st_res_instr", if_instr, 8'hA5);
    chk("st_res_addr", imem_addr, 8'h11);
    flush = 1'b1; stall = 1'b1; redirect_pc = 8'h40;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("fs_addr", imem_addr, 8'h40);
    chk("fs_valid", {7'd0, if_valid}, 8'h00);
    chk("fs_instr", if_instr, 8'h00);
    flush = 1'b1; redirect_pc = 8'hFF;
    step();
    flush = 1'b0;
    step();
    chk("wrap_instr", if_instr, 8'h21);
    chk("wrap_pcn", if_pc_next, 8'h00);
    chk("wrap_addr", imem_addr, 8'h00);
    flush = 1'b1; redirect_pc = 8'h20;
    step();
    flush = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    chk("h_hlt", {7'd0, hlt_o}, 8'h01);
    chk("h_valid", {7'd0, if_valid}, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("h_addr", imem_addr, 8'h20);
      chk("h_hold", {7'd0, hlt_o}, 8'h01);
    end
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    chk("hi_pend", {7'd0, dut.int_pending}, 8'h01);
    step();
    chk("hi_hlt", {7'd0, hlt_o}, 8'h00);
    chk("hi_int", {7'd0, if_int}, 8'h01);
    chk("hi_pcn", if_pc_next, 8'h20);
    step();
    chk("hi_vec", imem_addr, 8'h6E);
    step();
    chk("hi_run_instr", if_instr, 8'h44);
    rst = 1'b1;
    #1;
    chk_reset("mrst");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mrst_vec", dut.pc, 8'h02);
    // held-high interrupt must be taken exactly once
    int_req = 1'b1;
    step();
    chk("hh_pend", {7'd0, dut.int_pending}, 8'h01);
    step();
    chk("hh_bub", {7'd0, if_int}, 8'h01);
    chk("hh_pcn", if_pc_next, 8'h03);
    step();
    chk("hh_vec", imem_addr, 8'h6E);
    step();
    chk("hh_once_pend", {7'd0, dut.int_pending}, 8'h00);
    chk("hh_once_valid", {7'd0, if_valid}, 8'h01);
    chk("hh_once_addr", imem_addr, 8'h6F);
    int_req = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
